lut_coord_unpack: RTL and testbench
===================================

# lut_coord_unpack

Downstream consumer of the `sim_lut` rectification LUT stream. It accepts packed LUT words over a valid/ready/last handshake and unpacks each word into integer and fractional source-pixel coordinates. It tags each coordinate with the output raster position: line-end and frame-end flags. It also checks frame framing against `ltlast` and presents a registered, back-pressurable coordinate stream to the pixel-fetch/interpolation stage.

## Interface

**Parameters**
- `IMG_W`, 640: output pixels per line.
- `IMG_H`, 480: output lines per frame.
- `XI_W`, 11: integer x width.
- `YI_W`, 11: integer y width.
- `F_W`, 5: fractional width (x and y).
- `DATA_W` is derived, not settable: 2*F_W+XI_W+YI_W, which is 32.

**Ports**
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ltvalid` in 1: LUT word valid.
- `ltdata` in DATA_W: packed LUT word. Fields: `{x_int[XI_W], x_frac[F_W], y_int[YI_W], y_frac[F_W]}`, MSB first.
- `ltlast` in 1: last LUT word of frame.
- `ltready` out 1: registered ready to the LUT source.
- `cvalid` out 1: coordinate valid.
- `cready` in 1: downstream ready.
- `cx` out XI_W: source x integer.
- `cfx` out F_W: source x fraction.
- `cy` out YI_W: source y integer.
- `cfy` out F_W: source y fraction.
- `coob` out 1: coordinate was clamped (out of image).
- `clast_line` out 1: beat is the last pixel of the output line.
- `clast_frame` out 1: beat is the last pixel of the frame.
- `err_last` out 1: sticky framing error.
- `frame_done` out 1: one-cycle pulse on acceptance of the frame-end beat at the output.

## Operation

**Buffering**
- Two-stage skid buffer: output register (OR) plus skid register (SR).
- `ltready` is registered and equals NOT SR-full.
- Input is accepted on `ltvalid & ltready`.
- Output beat is transferred on `cvalid & cready`.
- An accepted word goes to OR if OR is empty or is transferring this cycle; otherwise it goes to SR.
- SR drains into OR on the first output transfer.

**Unpack and clamp**, applied on entry to the buffer:
- If `x_int >= IMG_W`: `cx = IMG_W-1`, `cfx = 0`, `coob = 1`.
- If `y_int >= IMG_H`: `cy = IMG_H-1`, `cfy = 0`, `coob = 1`.
- Otherwise fields pass through unchanged and `coob = 0`.

**Position counters** `col` (0..IMG_W-1) and `row` (0..IMG_H-1)
- Advance per accepted input word and are captured with the word.
- `clast_line = (col == IMG_W-1)`.
- `clast_frame = clast_line & (row == IMG_H-1)`.
- On the last column, `col` wraps to 0 and `row` increments.
- On the frame-end word, both counters wrap to 0.

**Framing check**, on each accepted word:
- `ltlast=1` on a word that is not frame-end: set `err_last`, force `clast_line=clast_frame=1` on that beat, reset counters to 0 (resynchronise).
- `ltlast=0` on the frame-end word: set `err_last`, wrap counters normally.
- `err_last` stays set until `rst`.

**Reset**
- Flushes both buffer stages and zeroes the counters.
- A frame in progress is discarded; the next accepted word is treated as col 0, row 0.

## Timing

- Reset values:
  - `ltready=0`, `cvalid=0`, `cx=cy=cfx=cfy=0`, `coob=0`, `clast_line=clast_frame=0`, `err_last=0`, `frame_done=0`.
  - `ltready` rises the first cycle after `rst` deasserts.
- Latency: a word accepted at edge N is on the outputs with `cvalid=1` after edge N, when OR is empty or transferring.
- Throughput: one word per cycle with `cready` held high; no bubbles.
- Back-pressure: with `cready=0`, at most 2 words are accepted. `ltready` falls the cycle after SR fills, and rises the cycle after SR drains.
- Outputs are held stable while `cvalid & ~cready`.
- `frame_done` pulses in the same cycle as the output transfer of a `clast_frame` beat.
- Simultaneous input accept and output transfer with SR empty: OR is reloaded directly and SR stays empty.

## Test plan

Bench settings: `IMG_W=4`, `IMG_H=2`.

1. **Reset:** hold `rst` 3 cycles, then release.
   - During reset all outputs are 0.
   - `ltready=1` one cycle after release.
   - `cvalid=0` until the first word.
2. **Streaming:** stream 8 words with `cready=1`, `ltlast` on word 8. Word 0 is `ltdata=32'h0020_1084`.
   - Word 0 decodes to `cx=1`, `cfx=0`, `cy=132`, `cfy=4`; with `IMG_H=2`, y clamps to `cy=1`, `cfy=0`, `coob=1`.
   - `clast_line` on beats 4 and 8.
   - `clast_frame` and `frame_done` on beat 8.
   - `err_last=0`.
3. **Back-pressure:** `cready` pattern 0,0,0,1,0,1,1 while `ltvalid=1`.
   - Exactly 2 words are accepted before `ltready=0`.
   - No word is lost or duplicated.
   - Output order equals input order.
   - Outputs are stable while stalled.
4. **Early last:** `ltlast=1` on word 3 of a frame.
   - Beat 3 carries `clast_line=clast_frame=1`.
   - `err_last=1` and remains 1.
   - The next word is at col 0, row 0.
5. **Missing last:** 8 words with `ltlast=0`.
   - Beat 8 still has `clast_frame=1`.
   - `err_last=1`.
   - Word 9 starts a new frame at col 0.
6. **Reset mid-frame:** assert `rst` after 5 words while stalled.
   - Buffers flush (`cvalid=0`).
   - `err_last=0`.
   - Post-reset word 1 is col 0, row 0.

Source files
------------

// File: rtl/lut_coord_unpack.sv
// Unpacks rectification LUT words into clamped source coordinates tagged with raster position,
// checks frame framing against ltlast and presents them through a two-entry skid buffer.
module lut_coord_unpack #(
    parameter  int IMG_W  = 640,
    parameter  int IMG_H  = 480,
    parameter  int XI_W   = 11,
    parameter  int YI_W   = 11,
    parameter  int F_W    = 5,
    localparam int DATA_W = 2*F_W + XI_W + YI_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ltvalid,
    input  logic [DATA_W-1:0] ltdata,
    input  logic              ltlast,
    output logic              ltready,
    output logic              cvalid,
    input  logic              cready,
    output logic [XI_W-1:0]   cx,
    output logic [F_W-1:0]    cfx,
    output logic [YI_W-1:0]   cy,
    output logic [F_W-1:0]    cfy,
    output logic              coob,
    output logic              clast_line,
    output logic              clast_frame,
    output logic              err_last,
    output logic              frame_done
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XI_W-1:0]  X_MAX    = XI_W'(IMG_W - 1);
    localparam logic [YI_W-1:0]  Y_MAX    = YI_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    typedef struct packed {
        logic [XI_W-1:0] x;
        logic [F_W-1:0]  fx;
        logic [YI_W-1:0] y;
        logic [F_W-1:0]  fy;
        logic            oob;
        logic            last_line;
        logic            last_frame;
    } beat_t;

    logic [XI_W-1:0]  x_int;
    logic [F_W-1:0]   x_frac;
    logic [YI_W-1:0]  y_int;
    logic [F_W-1:0]   y_frac;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             at_eol, frame_end, early_last, x_oob, y_oob;
    logic             accept, xfer;
    beat_t            in_beat, or_q, or_n, sr_q, sr_n;
    logic             or_v, or_v_n, sr_v, sr_v_n;

    assign {x_int, x_frac, y_int, y_frac} = ltdata;

    assign accept     = ltvalid & ltready;
    assign xfer       = or_v & cready;
    assign at_eol     = (col == COL_LAST);
    assign frame_end  = at_eol & (row == ROW_LAST);
    assign early_last = ltlast & ~frame_end;
    assign x_oob      = (x_int > X_MAX);
    assign y_oob      = (y_int > Y_MAX);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        in_beat            = '0;
        in_beat.x          = x_oob ? X_MAX : x_int;
        in_beat.fx         = x_oob ? '0 : x_frac;
        in_beat.y          = y_oob ? Y_MAX : y_int;
        in_beat.fy         = y_oob ? '0 : y_frac;
        in_beat.oob        = x_oob | y_oob;
        // An early ltlast closes the line and frame on this beat so downstream resynchronises too.
        in_beat.last_line  = at_eol | early_last;
        in_beat.last_frame = frame_end | early_last;
    end

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col      <= '0;
            row      <= '0;
            err_last <= 1'b0;
        end else if (accept) begin
            if (ltlast | frame_end) begin
                col <= '0;
                row <= '0;
            end else if (at_eol) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
            if (ltlast ^ frame_end)
                err_last <= 1'b1;
        end
    end

    // Skid buffer: SR only ever fills while OR is stalled, and empties into OR on the next transfer.
    always_comb begin
        or_n   = or_q;
        or_v_n = or_v;
        sr_n   = sr_q;
        sr_v_n = sr_v;
        if (xfer) begin
            if (sr_v) begin
                or_n   = sr_q;
                sr_v_n = 1'b0;
            end else if (accept) begin
                or_n = in_beat;
            end else begin
                or_v_n = 1'b0;
            end
        end else if (accept) begin
            if (!or_v) begin
                or_n   = in_beat;
                or_v_n = 1'b1;
            end else begin
                sr_n   = in_beat;
                sr_v_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            or_v    <= 1'b0;
            sr_v    <= 1'b0;
            or_q    <= '0;
            ltready <= 1'b0;
        end else begin
            or_v    <= or_v_n;
            sr_v    <= sr_v_n;
            or_q    <= or_n;
            ltready <= ~sr_v_n;
        end
    end

    // NOTE: the skid payload is never observed without sr_v, so it needs no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_n;
    end

    assign cvalid      = or_v;
    assign cx          = or_q.x;
    assign cfx         = or_q.fx;
    assign cy          = or_q.y;
    assign cfy         = or_q.fy;
    assign coob        = or_q.oob;
    assign clast_line  = or_q.last_line;
    assign clast_frame = or_q.last_frame;
    assign frame_done  = or_v & cready & or_q.last_frame;

endmodule

// File: tb/tb_lut_coord_unpack.sv
// Directed bench for lut_coord_unpack at IMG_W=4, IMG_H=2: decode/clamp, raster tags,
// framing errors, back-pressure and reset flush, against hand-computed beats.
module tb_lut_coord_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ltvalid = 1'b0;
    logic [31:0] ltdata = '0;
    logic        ltlast = 1'b0;
    logic        ltready;
    logic        cvalid;
    logic        cready = 1'b1;
    logic [10:0] cx;
    logic [4:0]  cfx;
    logic [10:0] cy;
    logic [4:0]  cfy;
    logic        coob, clast_line, clast_frame, err_last, frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cycles = 0;
    logic [63:0] got_q[$];
    logic [63:0] exp_q[$];

    lut_coord_unpack #(.IMG_W(4), .IMG_H(2)) dut (
        .clk(clk), .rst(rst), .ltvalid(ltvalid), .ltdata(ltdata), .ltlast(ltlast),
        .ltready(ltready), .cvalid(cvalid), .cready(cready), .cx(cx), .cfx(cfx),
        .cy(cy), .cfy(cfy), .coob(coob), .clast_line(clast_line),
        .clast_frame(clast_frame), .err_last(err_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int xi, input int xf, input int yi, input int yf);
        return {11'(xi), 5'(xf), 11'(yi), 5'(yf)};
    endfunction

    function automatic logic [63:0] bt(input logic [10:0] x, input logic [4:0] fx,
                                       input logic [10:0] y, input logic [4:0] fy,
                                       input logic oob, input logic cl, input logic cf,
                                       input logic fd);
        return 64'({x, fx, y, fy, oob, cl, cf, fd});
    endfunction

    // frame_done is sampled only on transfers, so it must equal clast_frame there.
    task automatic exp_push(input int x, input int fx, input int y, input int fy,
                            input logic oob, input logic cl, input logic cf);
        exp_q.push_back(bt(11'(x), 5'(fx), 11'(y), 5'(fy), oob, cl, cf, cf));
    endtask

    always @(negedge clk) begin
        if (!rst && cvalid && cready)
            got_q.push_back(bt(cx, cfx, cy, cfy, coob, clast_line, clast_frame, frame_done));
    end

    task automatic send(input logic [31:0] w, input logic last);
        int n = 0;
        ltvalid = 1'b1;
        ltdata  = w;
        ltlast  = last;
        @(negedge clk);
        while (!ltready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ltready) check("send_ready_timeout", ltready, 1);
        stall_cycles += n;
        @(posedge clk);
        #1;
        ltvalid = 1'b0;
        ltlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = exp_q.size();
        int t = 0;
        while (got_q.size() < n && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_count"}, got_q.size(), n);
        for (int k = 0; k < n && k < got_q.size(); k++)
            check($sformatf("%s_beat%0d", tag, k), got_q[k], exp_q[k]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset(input string tag);
        rst     = 1'b1;
        ltvalid = 1'b0;
        ltlast  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_outputs_zero"},
              64'({ltready, cvalid, cx, cfx, cy, cfy, coob, clast_line, clast_frame,
                   err_last, frame_done}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ltready_low_at_release"}, ltready, 0);
        @(posedge clk);
        #1;
        check({tag, "_ltready_high_after"}, ltready, 1);
        check({tag, "_cvalid_idle"}, cvalid, 0);
    endtask

    initial begin
        int pat[7]     = '{0, 0, 0, 1, 0, 1, 1};
        int exp_rdy[7] = '{1, 1, 0, 0, 1, 0, 1};
        logic [31:0] bp_w[4];
        logic [63:0] held;
        logic        held_v;
        logic        acc;
        int          n_acc;

        // Reset
        @(posedge clk);
        #1;
        do_reset("t1");

        // Streaming: one full frame, cready high throughout
        stall_cycles = 0;
        send(32'h0020_1084, 1'b0);
        check("t2_latency_cvalid", cvalid, 1);
        send(pk(3, 7, 0, 9), 1'b0);
        send(pk(2, 31, 1, 31), 1'b0);
        send(pk(4, 5, 1, 2), 1'b0);
        send(pk(0, 0, 0, 0), 1'b0);
        send(pk(2047, 31, 2047, 31), 1'b0);
        send(pk(1, 16, 0, 1), 1'b0);
        send(pk(3, 1, 1, 1), 1'b1);
        check("t2_no_input_stall", stall_cycles, 0);
        exp_push(1, 0, 1, 0, 1, 0, 0);
        exp_push(3, 7, 0, 9, 0, 0, 0);
        exp_push(2, 31, 1, 31, 0, 0, 0);
        exp_push(3, 0, 1, 2, 1, 1, 0);
        exp_push(0, 0, 0, 0, 0, 0, 0);
        exp_push(3, 0, 1, 0, 1, 0, 0);
        exp_push(1, 16, 0, 1, 0, 0, 0);
        exp_push(3, 1, 1, 1, 0, 1, 1);
        drain("t2");
        check("t2_err_last", err_last, 0);

        // Back-pressure: cready 0,0,0,1,0,1,1 with ltvalid held
        bp_w[0] = pk(0, 1, 0, 1);
        bp_w[1] = pk(1, 2, 1, 2);
        bp_w[2] = pk(2, 3, 0, 3);
        bp_w[3] = pk(3, 4, 1, 4);
        n_acc  = 0;
        held_v = 1'b0;
        held   = '0;
        for (int i = 0; i < 7; i++) begin
            cready  = pat[i][0];
            ltvalid = (n_acc < 4);
            ltdata  = bp_w[(n_acc < 4) ? n_acc : 3];
            ltlast  = 1'b0;
            @(negedge clk);
            check($sformatf("t3_ltready_c%0d", i), ltready, exp_rdy[i]);
            if (held_v)
                check($sformatf("t3_hold_c%0d", i),
                      64'({cx, cfx, cy, cfy, coob, clast_line, clast_frame}), held);
            held_v = cvalid && !cready;
            held   = 64'({cx, cfx, cy, cfy, coob, clast_line, clast_frame});
            if (i == 2) check("t3_accepted_before_full", n_acc, 2);
            acc = ltvalid && ltready;
            @(posedge clk);
            #1;
            if (acc) n_acc++;
        end
        ltvalid = 1'b0;
        cready  = 1'b1;
        check("t3_total_accepted", n_acc, 4);
        exp_push(0, 1, 0, 1, 0, 0, 0);
        exp_push(1, 2, 1, 2, 0, 0, 0);
        exp_push(2, 3, 0, 3, 0, 0, 0);
        exp_push(3, 4, 1, 4, 0, 1, 0);
        drain("t3");
        for (int k = 0; k < 4; k++) begin
            send(pk(k, 9, 0, 9), k == 3);
            exp_push(k, 9, 0, 9, 0, k == 3, k == 3);
        end
        drain("t3_tail");
        check("t3_err_last", err_last, 0);

        // Early last on word 3
        send(pk(1, 1, 1, 1), 1'b0);
        send(pk(2, 2, 1, 2), 1'b0);
        send(pk(3, 3, 0, 3), 1'b1);
        exp_push(1, 1, 1, 1, 0, 0, 0);
        exp_push(2, 2, 1, 2, 0, 0, 0);
        exp_push(3, 3, 0, 3, 0, 1, 1);
        drain("t4_early");
        check("t4_err_set", err_last, 1);
        for (int k = 0; k < 8; k++) begin
            send(pk(k % 4, k, k / 4, k), k == 7);
            exp_push(k % 4, k, k / 4, k, 0, (k % 4) == 3, k == 7);
        end
        drain("t4_resync");
        check("t4_err_sticky", err_last, 1);

        // Missing last
        do_reset("t5");
        check("t5_err_cleared", err_last, 0);
        for (int k = 0; k < 8; k++) begin
            send(pk(k % 4, 2, k / 4, 3), 1'b0);
            exp_push(k % 4, 2, k / 4, 3, 0, (k % 4) == 3, k == 7);
        end
        drain("t5_missing");
        check("t5_err_set", err_last, 1);
        for (int k = 0; k < 8; k++) begin
            send(pk(k % 4, 4, k / 4, 5), k == 7);
            exp_push(k % 4, 4, k / 4, 5, 0, (k % 4) == 3, k == 7);
        end
        drain("t5_next_frame");

        // Reset mid-frame while stalled
        for (int k = 0; k < 5; k++) begin
            send(pk(k % 4, 6, k / 4, 6), 1'b0);
            exp_push(k % 4, 6, k / 4, 6, 0, (k % 4) == 3, 0);
        end
        drain("t6_pre");
        cready = 1'b0;
        send(pk(1, 7, 1, 7), 1'b0);
        send(pk(2, 7, 1, 7), 1'b0);
        check("t6_stalled_cvalid", cvalid, 1);
        check("t6_stalled_ltready", ltready, 0);
        do_reset("t6");
        check("t6_err_cleared", err_last, 0);
        cready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send(pk(k % 4, 8, k / 4, 8), k == 7);
            exp_push(k % 4, 8, k / 4, 8, 0, (k % 4) == 3, k == 7);
        end
        drain("t6_post");
        check("t6_err_after_frame", err_last, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
